lsb_gen: RTL
============

Name: lsb_gen

Overview:
- Parametrised LEDs/Switches/Buttons/7-segment I/O block.
- Successor of the fixed-size board LSB: generic counts of red/green LEDs, switches, buttons and hex digits.
- Adds debounced inputs, sticky button-press events with an interrupt line, and red-LED load/on/off/toggle modes.
- Sits on the CPU I/O bus as a 4-word device; red LEDs can also be driven directly by hardware signals.

Parameters:
- BOARD, 4'd3: board id returned in read data [31:28].
- NUM_LEDR, 10: red LEDs, 1..28.
- NUM_LEDG, 8: green LEDs, 1..32.
- NUM_SWI, 10: switches, 1..16.
- NUM_BTN, 4: buttons, 1..8.
- NUM_HEX, 4: 7-segment digits, 1..8.
- DEB_W, 16: debounce counter width.
- DEB_CYCLES, 50000: stable cycles required before a debounced input changes; must be < 2^DEB_W.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- stb  in  1  bus strobe.
- we  in  1  write enable.
- addr  in  2  register select.
- data_in  in  32  write data.
- leds_r_in  in  NUM_LEDR  direct hardware LED drive; must be clk-synchronous.
- data_out  out  32  read data.
- ack  out  1  bus acknowledge.
- btn_in_n  in  NUM_BTN  raw buttons, active low.
- swi_in  in  NUM_SWI  raw switches.
- leds_r  out  NUM_LEDR  red LEDs.
- leds_g  out  NUM_LEDG  green LEDs.
- hex_n  out  7*NUM_HEX  segments, active low; digit i occupies [7i+6:7i].
- btn_out  out  NUM_BTN  debounced buttons, active high.
- swi_out  out  NUM_SWI  debounced switches.
- irq  out  1  high while any button event flag is set.

Behaviour:
- Reset (async on rst_n low, released synchronously on design side):
  - leds_g=0, leds_r_d=0, leds_r_s=0, events=0.
  - hex_n all 1s (all digits dark).
  - Sync flops, debounce counters, stable btn/swi = 0 (btn stable = not pressed).
  - irq=0.
- Bus:
  - ack=stb, combinational, zero wait.
  - data_out=0 unless stb&~we.
  - Writes take effect on the clk edge with stb&we.
- addr 0:
  - Write: leds_g <= data_in[NUM_LEDG-1:0].
  - Read: {BOARD, zero pad, swi_out} with swi_out right-aligned in [15:0].
- addr 1, red LEDs, mask m = data_in[NUM_LEDR-1:0], mode = data_in[31:30]:
  - 00 load: leds_r_d <= m.
  - 01 off: &~m.
  - 10 on: |m.
  - 11 toggle: ^m.
  - Read returns {4'b0, zero pad, leds_r}.
  - leds_r = leds_r_s | leds_r_d, where leds_r_s is leds_r_in registered one cycle.
- addr 2, hex write:
  - idx = data_in[10:8], val = data_in[3:0].
  - data_in[4]=1: blank digit (all 1s).
  - data_in[5]=1: raw mode, segments_n <= ~data_in[22:16].
  - Otherwise: hex LUT 0-F, active low.
  - idx >= NUM_HEX: write ignored.
  - Read returns 0.
- addr 3, button events:
  - Read: events right-aligned, btn_out in [15:8].
  - Write: write-1-to-clear using data_in[NUM_BTN-1:0].
  - Set on a debounced rising edge of btn_out[i] (a press).
  - Set and clear in the same cycle: set wins.
- Debounce, per input:
  - 2-FF synchroniser, then counter.
  - Synced == stable: counter <= 0.
  - Otherwise counter increments; when it reaches DEB_CYCLES-1, stable <= synced and counter <= 0.
  - Total latency from pin change to output: DEB_CYCLES+2 cycles.
  - A glitch shorter than DEB_CYCLES restarts the count; no output change.
- irq = |events, registered; asserts the cycle after the event flag sets.

Optional Feature:
- Macro LSB_BLINK_EN.
- Defined:
  - addr 1 writes with data_in[29]=1 load blink_mask <= m instead of applying the mode.
  - A free-running BLINK_W=24 bit prescaler; phase = its MSB.
  - leds_r = leds_r_s | (leds_r_d & ~(blink_mask & {NUM_LEDR{phase}})).
  - blink_mask and prescaler reset to 0.
- Undefined: addr 1 writes with data_in[29]=1 are ignored; no prescaler logic exists.

Test Plan:
- Reset, then read addr 0 with swi_in=10'h2A5, DEB_CYCLES=4 -> data_out=0 during reset; 32'h3000_02A5 after 6+ cycles.
- Write addr 1 = 32'h0000_0005, then 32'h8000_0002 (on), then 32'hC000_0007 (toggle) -> leds_r 0x005, 0x007, 0x000; leds_r_in=0x200 -> leds_r=0x200 one cycle later.
- Write addr 2 = 32'h0000_0203 -> hex_n[20:14]=~7'b1001111. Then 32'h0000_0210 -> digit 2 dark. Then idx 5 with NUM_HEX=4 -> no hex_n change.
- btn_in_n[1] low for 3 cycles then high (DEB_CYCLES=4) -> no event. Low for 10 cycles -> btn_out[1]=1 six cycles after the fall, events[1]=1, irq=1 next cycle.
- Write addr 3 = 32'h2 in the same cycle as a new btn[1] press edge -> events[1] stays 1. Clean clear -> events=0, irq=0 next cycle.
- With LSB_BLINK_EN: write 32'h2000_0001, then load 0x001 -> leds_r[0] follows prescaler MSB. Without the macro, same writes -> leds_r[0] steady 1.

Source files
------------

// File: rtl/lsb_gen.sv
// lsb_gen: parametrised LEDs / switches / buttons / 7-segment I/O block on a
// 4-word CPU bus. Inputs are synchronised and debounced. Button presses set
// sticky event flags that drive an interrupt line. Red LEDs can be loaded or
// masked on/off/toggled over the bus, and can also be driven by hardware.
// Optional feature: define LSB_BLINK_EN to add per-LED blinking driven by a
// free-running prescaler.
module lsb_gen #(
  parameter logic [3:0] BOARD      = 4'd3,
  parameter int         NUM_LEDR   = 10,
  parameter int         NUM_LEDG   = 8,
  parameter int         NUM_SWI    = 10,
  parameter int         NUM_BTN    = 4,
  parameter int         NUM_HEX    = 4,
  parameter int         DEB_W      = 16,
  parameter int         DEB_CYCLES = 50000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_stb,
  input  logic                   i_we,
  input  logic [1:0]             i_addr,
  input  logic [31:0]            i_dataIn,
  input  logic [NUM_LEDR-1:0]    i_ledsRIn,
  output logic [31:0]            o_dataOut,
  output logic                   o_ack,
  input  logic [NUM_BTN-1:0]     i_btnInN,
  input  logic [NUM_SWI-1:0]     i_swiIn,
  output logic [NUM_LEDR-1:0]    o_ledsR,
  output logic [NUM_LEDG-1:0]    o_ledsG,
  output logic [7*NUM_HEX-1:0]   o_hexN,
  output logic [NUM_BTN-1:0]     o_btnOut,
  output logic [NUM_SWI-1:0]     o_swiOut,
  output logic                   o_irq
);

  // Buttons occupy the low bits of the debounce vector, switches the high bits.
  localparam int NUM_DEB = NUM_BTN + NUM_SWI;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic                         w_wr;
  logic                         w_wr0;
  logic                         w_wr1;
  logic                         w_wr2;
  logic                         w_wr3;
  logic [NUM_DEB-1:0]           w_rawIn;
  logic [NUM_DEB-1:0]           w_debFire;
  logic [NUM_BTN-1:0]           w_btnRise;
  logic [NUM_LEDR-1:0]          w_mask;
  logic [6:0]                   w_hexLut;
  logic [6:0]                   w_segN;
  logic                         w_unused;

  logic [NUM_DEB-1:0]           r_sync1;
  logic [NUM_DEB-1:0]           r_sync2;
  logic [NUM_DEB-1:0]           r_stable;
  logic [NUM_DEB-1:0][DEB_W-1:0] r_debCnt;
  logic [NUM_BTN-1:0]           r_events;
  logic                         r_irq;
  logic [NUM_LEDG-1:0]          r_ledsG;
  logic [NUM_LEDR-1:0]          r_ledsRD;
  logic [NUM_LEDR-1:0]          r_ledsRS;
  logic [7*NUM_HEX-1:0]         r_hexN;

  assign w_wr  = i_stb & i_we;
  assign w_wr0 = w_wr & (i_addr == 2'd0);
  assign w_wr1 = w_wr & (i_addr == 2'd1);
  assign w_wr2 = w_wr & (i_addr == 2'd2);
  assign w_wr3 = w_wr & (i_addr == 2'd3);
  assign w_mask = i_dataIn[NUM_LEDR-1:0];

  // Buttons are inverted before synchronising so that a zero everywhere means "not pressed".
  assign w_rawIn = {i_swiIn, ~i_btnInN};

  // Data bits not decoded by every configuration are gathered here on purpose.
  assign w_unused = &{1'b0, i_dataIn};

  // Two-flop synchroniser for all raw switch and button inputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_rawIn;
      r_sync2 <= r_sync1;
    end
  end

  // An input commits to its new level once the count of differing cycles reaches the limit.
  always_comb begin
    w_debFire = '0;
    for (int i = 0; i < NUM_DEB; i++) begin
      w_debFire[i] = (r_sync2[i] != r_stable[i]) && (r_debCnt[i] == DEB_LAST);
    end
  end

  // Debounce counters: any return to the stable level restarts the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_debCnt <= '0;
      r_stable <= '0;
    end else begin
      for (int i = 0; i < NUM_DEB; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_debCnt[i] <= '0;
        end else if (w_debFire[i]) begin
          r_stable[i] <= r_sync2[i];
          r_debCnt[i] <= '0;
        end else begin
          r_debCnt[i] <= r_debCnt[i] + DEB_W'(1);
        end
      end
    end
  end

  assign o_btnOut  = r_stable[NUM_BTN-1:0];
  assign o_swiOut  = r_stable[NUM_DEB-1:NUM_BTN];
  assign w_btnRise = w_debFire[NUM_BTN-1:0] & r_sync2[NUM_BTN-1:0];

  // Sticky press events, write-1-to-clear; a press in the same cycle as a clear keeps the flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_events <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (w_btnRise[i]) begin
          r_events[i] <= 1'b1;
        end else if (w_wr3 && i_dataIn[i]) begin
          r_events[i] <= 1'b0;
        end
      end
    end
  end

  // Interrupt follows the event flags one cycle later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |r_events;
    end
  end

  assign o_irq = r_irq;

  // Green LED register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ledsG <= '0;
    end else if (w_wr0) begin
      r_ledsG <= i_dataIn[NUM_LEDG-1:0];
    end
  end

  assign o_ledsG = r_ledsG;

  // Red LEDs: bus-driven register with load/off/on/toggle, plus registered hardware drive.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ledsRD <= '0;
      r_ledsRS <= '0;
    end else begin
      r_ledsRS <= i_ledsRIn;
      if (w_wr1 && !i_dataIn[29]) begin
        case (i_dataIn[31:30])
          2'b00:   r_ledsRD <= w_mask;
          2'b01:   r_ledsRD <= r_ledsRD & ~w_mask;
          2'b10:   r_ledsRD <= r_ledsRD | w_mask;
          default: r_ledsRD <= r_ledsRD ^ w_mask;
        endcase
      end
    end
  end

`ifdef LSB_BLINK_EN
  localparam int BLINK_W = 24;

  logic [BLINK_W-1:0]  r_prescaler;
  logic [NUM_LEDR-1:0] r_blinkMask;

  // Free-running blink prescaler and the mask of LEDs that blink with its MSB.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prescaler <= '0;
      r_blinkMask <= '0;
    end else begin
      r_prescaler <= r_prescaler + BLINK_W'(1);
      if (w_wr1 && i_dataIn[29]) begin
        r_blinkMask <= w_mask;
      end
    end
  end

  assign o_ledsR = r_ledsRS | (r_ledsRD & ~(r_blinkMask & {NUM_LEDR{r_prescaler[BLINK_W-1]}}));
`else
  assign o_ledsR = r_ledsRS | r_ledsRD;
`endif

  // Hex-to-segment lookup, bit 0 = segment a through bit 6 = segment g, active high.
  always_comb begin
    w_hexLut = 7'h00;
    case (i_dataIn[3:0])
      4'h0: w_hexLut = 7'h3F;
      4'h1: w_hexLut = 7'h06;
      4'h2: w_hexLut = 7'h5B;
      4'h3: w_hexLut = 7'h4F;
      4'h4: w_hexLut = 7'h66;
      4'h5: w_hexLut = 7'h6D;
      4'h6: w_hexLut = 7'h7D;
      4'h7: w_hexLut = 7'h07;
      4'h8: w_hexLut = 7'h7F;
      4'h9: w_hexLut = 7'h6F;
      4'hA: w_hexLut = 7'h77;
      4'hB: w_hexLut = 7'h7C;
      4'hC: w_hexLut = 7'h39;
      4'hD: w_hexLut = 7'h5E;
      4'hE: w_hexLut = 7'h79;
      default: w_hexLut = 7'h71;
    endcase
  end

  // Segment pattern for a digit write: blank beats raw, raw beats the hex lookup.
  always_comb begin
    w_segN = ~w_hexLut;
    if (i_dataIn[4]) begin
      w_segN = 7'h7F;
    end else if (i_dataIn[5]) begin
      w_segN = ~i_dataIn[22:16];
    end
  end

  // Digit registers; an index beyond the fitted digits matches nothing and is dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hexN <= '1;
    end else if (w_wr2) begin
      for (int i = 0; i < NUM_HEX; i++) begin
        if (i_dataIn[10:8] == 3'(i)) begin
          r_hexN[7*i +: 7] <= w_segN;
        end
      end
    end
  end

  assign o_hexN = r_hexN;
  assign o_ack  = i_stb;

  // Read mux: zero unless a read strobe is active.
  always_comb begin
    o_dataOut = '0;
    if (i_stb && !i_we) begin
      case (i_addr)
        2'd0: begin
          o_dataOut[NUM_SWI-1:0] = o_swiOut;
          o_dataOut[31:28]       = BOARD;
        end
        2'd1: o_dataOut[NUM_LEDR-1:0] = o_ledsR;
        2'd2: o_dataOut = '0;
        default: begin
          o_dataOut[NUM_BTN-1:0]  = r_events;
          o_dataOut[8 +: NUM_BTN] = o_btnOut;
        end
      endcase
    end
  end

endmodule
